// File: rtl/jtframe_ddr_arb_if.sv
// Two-client DDR burst bus: per-client request/response signals plus the shared memory port.
// The slave modport is the arbiter's view; the master modport is the clients'/memory's view.
interface jtframe_ddr_arb_if;
    logic [31:3] c0_addr;
    logic [31:3] c1_addr;
    logic [7:0]  c0_burstcnt;
    logic [7:0]  c1_burstcnt;
    logic        c0_rd;
    logic        c0_we;
    logic        c1_rd;
    logic        c1_we;
    logic [63:0] c0_din;
    logic [63:0] c1_din;
    logic [7:0]  c0_be;
    logic [7:0]  c1_be;
    logic        c0_busy;
    logic        c1_busy;
    logic        c0_dout_ready;
    logic        c1_dout_ready;
    logic [63:0] c0_dout;
    logic [63:0] c1_dout;

    logic        ddram_clk;
    logic [31:3] ddram_addr;
    logic [7:0]  ddram_burstcnt;
    logic [63:0] ddram_din;
    logic [7:0]  ddram_be;
    logic        ddram_rd;
    logic        ddram_we;
    logic        ddram_busy;
    logic [63:0] ddram_dout;
    logic        ddram_dout_ready;

    modport slave (
        input  c0_addr, c1_addr, c0_burstcnt, c1_burstcnt,
        input  c0_rd, c0_we, c1_rd, c1_we,
        input  c0_din, c1_din, c0_be, c1_be,
        output c0_busy, c1_busy, c0_dout_ready, c1_dout_ready, c0_dout, c1_dout,
        output ddram_clk, ddram_addr, ddram_burstcnt, ddram_din, ddram_be,
        output ddram_rd, ddram_we,
        input  ddram_busy, ddram_dout, ddram_dout_ready
    );

    modport master (
        output c0_addr, c1_addr, c0_burstcnt, c1_burstcnt,
        output c0_rd, c0_we, c1_rd, c1_we,
        output c0_din, c1_din, c0_be, c1_be,
        input  c0_busy, c1_busy, c0_dout_ready, c1_dout_ready, c0_dout, c1_dout,
        input  ddram_clk, ddram_addr, ddram_burstcnt, ddram_din, ddram_be,
        input  ddram_rd, ddram_we,
        output ddram_busy, ddram_dout, ddram_dout_ready
    );
endinterface

// File: rtl/jtframe_ddr_arb.sv
// Two-client arbiter in front of a single DDR burst port: registered grant, combinational
// command mux, beat counting for read and write bursts, fixed-priority-with-starvation or round-robin.
module jtframe_ddr_arb #(
    parameter int RR     = 0,
    parameter int STARVE = 4
) (
    input  logic             clk,
    input  logic             rst,
    jtframe_ddr_arb_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    localparam logic [7:0] STARVE_L  = 8'(STARVE);
    localparam bit         RR_EN     = (RR != 0);
    localparam bit         STARVE_EN = (STARVE != 0);

    state_t     r_state;
    logic [7:0] r_beats;
    logic [7:0] r_streak;
    logic       r_last;
    logic       r_act;
    logic       r_rd;

    logic       w_req0;
    logic       w_req1;
    logic       w_gnt;
    logic       w_sel1;
    logic       w_cl_rd;
    logic       w_cl_we;
    logic [7:0] w_cl_cnt;
    logic [7:0] w_len;
    logic       w_rd_o;
    logic       w_we_o;
    logic       w_cmd_acc;
    logic       w_wbeat;
    logic       w_rbeat;
    logic       w_pick1;

    assign w_req0   = bus.c0_rd | bus.c0_we;
    assign w_req1   = bus.c1_rd | bus.c1_we;
    assign w_gnt    = (r_state != IDLE);
    assign w_sel1   = (r_state == G1);
    assign w_cl_rd  = w_sel1 ? bus.c1_rd : bus.c0_rd;
    assign w_cl_we  = w_sel1 ? bus.c1_we : bus.c0_we;
    assign w_cl_cnt = w_sel1 ? bus.c1_burstcnt : bus.c0_burstcnt;
    assign w_len    = (w_cl_cnt == 8'd0) ? 8'd1 : w_cl_cnt;

    // Once a read is accepted rd stays low for the rest of the grant; a write keeps forwarding we.
    assign w_rd_o    = w_gnt & ~r_act & w_cl_rd;
    assign w_we_o    = w_gnt & w_cl_we & (r_act ? ~r_rd : ~w_cl_rd);
    assign w_cmd_acc = w_gnt & ~r_act & (w_rd_o | w_we_o) & ~bus.ddram_busy;
    assign w_wbeat   = w_we_o & ~bus.ddram_busy;
    assign w_rbeat   = w_gnt & r_act & r_rd & bus.ddram_dout_ready;
    assign w_pick1   = RR_EN ? ~r_last : (STARVE_EN && (r_streak == STARVE_L));

    assign bus.ddram_clk      = clk;
    assign bus.ddram_addr     = w_sel1 ? bus.c1_addr : bus.c0_addr;
    assign bus.ddram_burstcnt = w_cl_cnt;
    assign bus.ddram_din      = w_sel1 ? bus.c1_din : bus.c0_din;
    assign bus.ddram_be       = w_sel1 ? bus.c1_be : bus.c0_be;
    assign bus.ddram_rd       = w_rd_o;
    assign bus.ddram_we       = w_we_o;

    assign bus.c0_busy       = (r_state == G0) ? bus.ddram_busy : 1'b1;
    assign bus.c1_busy       = (r_state == G1) ? bus.ddram_busy : 1'b1;
    assign bus.c0_dout_ready = (r_state == G0) & r_act & r_rd & bus.ddram_dout_ready;
    assign bus.c1_dout_ready = (r_state == G1) & r_act & r_rd & bus.ddram_dout_ready;
    assign bus.c0_dout       = bus.ddram_dout;
    assign bus.c1_dout       = bus.ddram_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_beats  <= 8'd0;
            r_streak <= 8'd0;
            r_last   <= 1'b1;
            r_act    <= 1'b0;
            r_rd     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_act <= 1'b0;
                    if (w_req0 && w_req1) begin
                        if (w_pick1) begin
                            r_state  <= G1;
                            r_last   <= 1'b1;
                            r_streak <= 8'd0;
                        end else begin
                            r_state <= G0;
                            r_last  <= 1'b0;
                            if (r_streak != 8'hFF) r_streak <= r_streak + 8'd1;
                        end
                    end else if (w_req0) begin
                        r_state  <= G0;
                        r_last   <= 1'b0;
                        r_streak <= 8'd0;
                    end else if (w_req1) begin
                        r_state  <= G1;
                        r_last   <= 1'b1;
                        r_streak <= 8'd0;
                    end
                end
                G0, G1: begin
                    if (!r_act) begin
                        if (w_cmd_acc) begin
                            r_act <= 1'b1;
                            r_rd  <= w_cl_rd;
                            // A write's first beat goes out with the command itself.
                            if (w_cl_rd) begin
                                r_beats <= w_len;
                            end else begin
                                r_beats <= w_len - 8'd1;
                                if (w_len == 8'd1) r_state <= IDLE;
                            end
                        end else if (!(w_cl_rd || w_cl_we)) begin
                            r_state <= IDLE;
                        end
                    end else if (r_rd ? w_rbeat : w_wbeat) begin
                        r_beats <= r_beats - 8'd1;
                        if (r_beats == 8'd1) r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
